// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl -- sequential unsigned shift-and-add multiplier.
//
// One shared N-bit ripple-carry adder (a chain of full_adder cells) is
// reused over N RUN iterations to build a 2N-bit product.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high, dominates every other input
//   start        request; sampled only in IDLE or DONE
//   A, B         N-bit unsigned multiplicand / multiplier, captured on accept
//   busy         high while in RUN
//   done         one-cycle pulse; P is valid from this cycle onward
//   P            2N-bit product register, held until next completion or reset
//   o_dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE) for checkers
//
// Handshake: an operation is accepted on any rising edge where start=1 and
// the FSM is in IDLE or DONE (and rst=0). busy rises in the cycle after the
// accepting edge and stays high for exactly N cycles; done is high for the
// single cycle after that, in which P already holds the new product. start is
// ignored during RUN, and A/B are don't-care after the accepting edge.
// -----------------------------------------------------------------------------

// 1-bit full adder cell.
//   a, b, cin : addends and carry-in
//   s, cout   : sum and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module mul_seq_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P,
  output logic [1:0]     o_dbg_state
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_m;
  logic [N-1:0]     r_acc;
  logic [N-1:0]     r_q;
  logic             r_c;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [2*N-1:0]   r_p;

  // Shared adder: ACC + (Q[0] ? M : 0), carry-in tied low.
  logic [N-1:0]     w_addend;
  logic [N-1:0]     w_sum;
  logic [N:0]       w_carry;
  logic             w_cout;
  logic [N-1:0]     w_acc_next;
  logic [N-1:0]     w_q_next;

  assign w_addend   = r_q[0] ? r_m : '0;
  assign w_carry[0] = 1'b0;

  for (genvar gi = 0; gi < N; gi++) begin : g_rca
    full_adder u_fa (
      .a    (r_acc[gi]),
      .b    (w_addend[gi]),
      .cin  (w_carry[gi]),
      .s    (w_sum[gi]),
      .cout (w_carry[gi+1])
    );
  end

  assign w_cout = w_carry[N];

  // {carry, sum, Q} shifted right by one: the carry-out becomes ACC's MSB and
  // the sum's LSB drops into Q, which is how the low half of the product forms.
  assign w_acc_next = {w_cout, w_sum[N-1:1]};
  assign w_q_next   = {w_sum[0], r_q[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_c     <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_p     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= A;
            r_q     <= B;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_q     <= w_q_next;
          r_c     <= w_cout;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(N - 1)) begin
            // Last iteration: publish the full product in one step.
            r_p     <= {w_acc_next, w_q_next};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign P           = r_p;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_ctrl -- self-checking bench for mul_seq_ctrl (N=4).
// Expected products come from plain integer multiplication of the operands
// queued at acceptance time; timing expectations come from the N+1 latency.
// -----------------------------------------------------------------------------
module tb_mul_seq_ctrl;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*N-1:0] P;
  logic [1:0]     dbg_state;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .P           (P),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int             n_checks = 0;
  int             n_pass   = 0;
  logic [2*N-1:0] exp_q[$];
  int             a_arr[$];
  int             b_arr[$];
  logic [2*N-1:0] last_p;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Runs the operations in a_arr/b_arr back to back with start held high,
  // dropping start after the last accept. With inject set, an extra start
  // pulse with new operands is issued during RUN and must be ignored.
  task automatic run_stream(input bit inject);
    int n;
    logic [2*N-1:0] want;
    n = a_arr.size();
    want = '0;
    A = N'(a_arr[0]);
    B = N'(b_arr[0]);
    start = 1'b1;
    for (int j = 0; j < n; j++) begin
      tick();  // accepting edge
      exp_q.push_back((2*N)'(a_arr[j] * b_arr[j]));
      if (j == n - 1) start = 1'b0;
      A = N'($urandom);
      B = N'($urandom);
      for (int c = 1; c <= N + 1; c++) begin
        if (inject && c == 2) begin
          start = 1'b1;
          A = 4'd2;
          B = 4'd2;
        end
        if (inject && c == 3) start = 1'b0;
        check("busy", 32'(busy), 32'(c <= N));
        check("done", 32'(done), 32'(c == N + 1));
        if (c == N + 1) begin
          want = exp_q.pop_front();
          check("product", 32'(P), 32'(want));
          if (j < n - 1) begin
            A = N'(a_arr[j+1]);
            B = N'(b_arr[j+1]);
          end
        end else begin
          tick();
        end
      end
    end
    // Cycle after the final done: back to idle, product held.
    tick();
    check("done_low_after", 32'(done), 32'd0);
    check("busy_low_after", 32'(busy), 32'd0);
    check("p_hold", 32'(P), 32'(want));
    last_p = want;
  endtask

  task automatic single(input int a, input int b);
    a_arr.delete();
    b_arr.delete();
    a_arr.push_back(a);
    b_arr.push_back(b);
    run_stream(1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    last_p = '0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_p", 32'(P), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    // Directed operands, including the all-ones carry case and zeros.
    single(7, 3);
    single(15, 15);
    single(0, 9);
    single(9, 0);
    single(1, 1);

    // Start pulse during RUN with changed operands is ignored.
    a_arr.delete(); b_arr.delete();
    a_arr.push_back(5); b_arr.push_back(6);
    run_stream(1'b1);

    // start held high: repeated 3x4, then 10x10 without an idle gap.
    a_arr.delete(); b_arr.delete();
    a_arr.push_back(3);  b_arr.push_back(4);
    a_arr.push_back(3);  b_arr.push_back(4);
    a_arr.push_back(10); b_arr.push_back(10);
    run_stream(1'b0);

    // Reset on the 2nd RUN cycle, with start also high: rst wins.
    A = 4'd12;
    B = 4'd13;
    start = 1'b1;
    tick();          // accept
    start = 1'b0;
    tick();          // second RUN cycle
    rst = 1'b1;
    start = 1'b1;
    tick();
    exp_q.delete();
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_p", 32'(P), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      tick();
      check("no_done_after_rst", 32'(done), 32'd0);
      check("idle_after_rst", 32'(busy), 32'd0);
    end
    single(12, 13);

    // Randomized streams of 1..3 operations.
    repeat (15) begin
      int len;
      len = $urandom_range(1, 3);
      a_arr.delete(); b_arr.delete();
      for (int k = 0; k < len; k++) begin
        a_arr.push_back($urandom_range(0, 15));
        b_arr.push_back($urandom_range(0, 15));
      end
      run_stream(1'b0);
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("idle_hold_p", 32'(P), 32'(last_p));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
